// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl
//   Backing-memory responder on the far side of the data cache's memory port.
//   Refill reads are answered after a fixed, programmable latency. Dirty-line
//   writebacks are absorbed into a posted write buffer, which drains one entry
//   per cycle into a word array. Reads forward from the buffer, so a writeback
//   followed by a refill of the same word returns the written value.
//
// Parameters
//   ADDR_BITS  word-address width; array depth is 2**ADDR_BITS 32-bit words
//   LATENCY    cycles from read acceptance to data capture (1..15)
//   WB_DEPTH   write-buffer entries (power of two, >= 2)
//
// Ports
//   clk       in   clock, all state updates on posedge
//   reset     in   asynchronous active-low reset
//   rd_req    in   refill read request (sampled only while rd_ready)
//   rd_addr   in   byte address; word index = rd_addr[ADDR_BITS+1:2]
//   rd_ready  out  read FSM idle, a read can be accepted
//   rd_valid  out  one-cycle pulse, rd_data valid
//   rd_data   out  response word, held until the next response
//   wr_req    in   writeback request
//   wr_addr   in   byte address; word index = wr_addr[ADDR_BITS+1:2]
//   wr_data   in   full-word writeback data
//   wr_ready  out  write buffer not full
//   wb_empty  out  write buffer holds no entries

module main_mem_ctrl #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4,
  parameter int WB_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        wb_empty
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam logic [PW:0] WB_FULL = (PW+1)'(WB_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Read FSM state
  logic [1:0]           r_state;
  logic [3:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_rd_idx;
  logic [31:0]          r_rd_data;

  // Word array (never reset)
  logic [31:0]          r_mem [2**ADDR_BITS];

  // Posted write buffer
  logic [ADDR_BITS-1:0] r_wb_addr [WB_DEPTH];
  logic [31:0]          r_wb_data [WB_DEPTH];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [PW:0]          r_count;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_capture;
  logic                 w_fwd_hit;
  logic [31:0]          w_fwd_data;
  logic [31:0]          w_rd_word;
  logic [ADDR_BITS-1:0] w_rd_idx_in;
  logic [ADDR_BITS-1:0] w_wr_idx_in;
  logic                 w_unused_bits;

  assign w_rd_idx_in = rd_addr[ADDR_BITS+1:2];
  assign w_wr_idx_in = wr_addr[ADDR_BITS+1:2];
  assign w_unused_bits = ^{rd_addr[31:ADDR_BITS+2], rd_addr[1:0],
                           wr_addr[31:ADDR_BITS+2], wr_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Write buffer
  // ---------------------------------------------------------------------------
  // wr_ready looks only at the registered count: a full buffer refuses a push
  // even on the edge where it drains an entry.
  assign wr_ready = (r_count != WB_FULL);
  assign wb_empty = (r_count == '0);
  assign w_push   = wr_req && wr_ready;
  assign w_pop    = (r_count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_tail] <= w_wr_idx_in;
      r_wb_data[r_tail] <= wr_data;
    end
  end

  // Drain: head entry goes to the array on every edge the buffer is non-empty.
  always_ff @(posedge clk) begin
    if (w_pop) r_mem[r_wb_addr[r_head]] <= r_wb_data[r_head];
  end

  // ---------------------------------------------------------------------------
  // Forwarding: scan valid entries oldest to newest so the last match wins.
  // The head is still valid in the cycle it drains, which covers the case of
  // the array write and the read capture landing on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (((PW+1)'(i) < r_count) &&
          (r_wb_addr[r_head + PW'(i)] == r_rd_idx)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_wb_data[r_head + PW'(i)];
      end
    end
  end

  assign w_rd_word = w_fwd_hit ? w_fwd_data : r_mem[r_rd_idx];

  // ---------------------------------------------------------------------------
  // Read FSM: IDLE -> WAIT -> RESP -> IDLE
  // ---------------------------------------------------------------------------
  assign w_capture = (r_state == S_WAIT) && (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rd_idx  <= '0;
      r_rd_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rd_req) begin
            r_rd_idx <= w_rd_idx_in;
            r_cnt    <= 4'(LATENCY - 1);
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_capture) begin
            r_rd_data <= w_rd_word;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_ready = (r_state == S_IDLE);
  assign rd_valid = (r_state == S_RESP);
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_main_mem_ctrl.sv
module tb_main_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        wb_empty;

  int n_tests = 0;
  int n_fail  = 0;

  main_mem_ctrl #(.ADDR_BITS(10), .LATENCY(4), .WB_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_req  = 1'b0;
  endtask

  task automatic wait_empty(output bit ok);
    ok = wb_empty;
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      ok = wb_empty;
    end
  endtask

  // Issue a read from IDLE, return the response word; ok=0 on timeout.
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output bit ok);
    rd_req  = 1'b1;
    rd_addr = a;
    step();
    rd_req  = 1'b0;
    ok = 1'b0;
    d  = '0;
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      if (rd_valid) begin
        ok = 1'b1;
        d  = rd_data;
      end
    end
    if (ok) step();
  endtask

  task automatic test_reset();
    reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    #2;
    n_tests++;
    if ({rd_valid, rd_ready, wr_ready, wb_empty} !== 4'b0111) begin
      n_fail++;
      $display("FAIL reset_flags: got v/rr/wr/e=%b want 0111",
               {rd_valid, rd_ready, wr_ready, wb_empty});
    end
    n_tests++;
    if (rd_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd_data: got %h want 00000000", rd_data);
    end
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_read_latency();
    bit ok;
    logic exp_v, exp_r;
    do_write(32'h14, 32'hDEAD_BEEF);
    wait_empty(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL lat_drain: got timeout want wb_empty"); end
    rd_req = 1'b1; rd_addr = 32'h14;
    step();  // edge N
    rd_req = 1'b0;
    n_tests++;
    if (rd_ready !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_edgeN: got rr=%b v=%b want rr=0 v=0", rd_ready, rd_valid);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_v = (k == 4);
      exp_r = (k == 5);
      n_tests++;
      if (rd_valid !== exp_v || rd_ready !== exp_r) begin
        n_fail++;
        $display("FAIL lat_edge%0d: got v=%b rr=%b want v=%b rr=%b", k, rd_valid, rd_ready, exp_v, exp_r);
      end
      if (k == 4) begin
        n_tests++;
        if (rd_data !== 32'hDEAD_BEEF) begin
          n_fail++; $display("FAIL lat_data: got %h want deadbeef", rd_data);
        end
      end
    end
  endtask

  task automatic test_forward();
    bit ok;
    logic [31:0] d;
    // Back-to-back writes then a read of the same word.
    wr_req = 1'b1; wr_addr = 32'h40; wr_data = 32'h1111_1111;
    step();
    wr_data = 32'h2222_2222;
    step();
    wr_req = 1'b0;
    do_read(32'h40, d, ok);
    n_tests++;
    if (!ok || d !== 32'h2222_2222) begin
      n_fail++; $display("FAIL fwd_b2b: got ok=%0d %h want 22222222", ok, d);
    end
    // Drain stalled: data can only come from the buffer, newest match wins.
    force dut.w_pop = 1'b0;
    do_write(32'h44, 32'h3333_0001);
    do_write(32'h44, 32'h3333_0002);
    do_write(32'h48, 32'h3333_0003);
    do_read(32'h44, d, ok);
    n_tests++;
    if (!ok || d !== 32'h3333_0002) begin
      n_fail++; $display("FAIL fwd_newest: got ok=%0d %h want 33330002", ok, d);
    end
    do_read(32'h48, d, ok);
    n_tests++;
    if (!ok || d !== 32'h3333_0003) begin
      n_fail++; $display("FAIL fwd_other: got ok=%0d %h want 33330003", ok, d);
    end
    release dut.w_pop;
    wait_empty(ok);
    do_read(32'h44, d, ok);
    n_tests++;
    if (!ok || d !== 32'h3333_0002) begin
      n_fail++; $display("FAIL fwd_drained: got ok=%0d %h want 33330002", ok, d);
    end
  endtask

  task automatic test_full_buffer();
    bit ok;
    logic [31:0] d;
    logic exp_r;
    int bad;
    // Steady drain keeps the buffer from filling.
    bad = 0;
    wr_req = 1'b1; wr_addr = 32'h50;
    for (int i = 0; i < 6; i++) begin
      wr_data = 32'hF000_0000 + 32'(i);
      step();
      if (wr_ready !== 1'b1) bad++;
    end
    wr_req = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL full_steady: got %0d cycles wr_ready=0 want 0", bad);
    end
    wait_empty(ok);
    do_read(32'h50, d, ok);
    n_tests++;
    if (!ok || d !== 32'hF000_0005) begin
      n_fail++; $display("FAIL full_steady_last: got ok=%0d %h want f0000005", ok, d);
    end
    // Stalled drain: four pushes then wr_ready drops.
    force dut.w_pop = 1'b0;
    wr_req = 1'b1; wr_addr = 32'h54;
    for (int i = 0; i < 6; i++) begin
      wr_data = 32'hE000_0000 + 32'(i);
      step();
      exp_r = (i < 3);
      n_tests++;
      if (wr_ready !== exp_r) begin
        n_fail++; $display("FAIL full_stall_edge%0d: got wr_ready=%b want %b", i + 1, wr_ready, exp_r);
      end
    end
    // Drain resumes on an edge where the buffer is still full: no push.
    wr_data = 32'hE000_0099;
    release dut.w_pop;
    step();
    wr_req = 1'b0;
    wait_empty(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL full_drain: got timeout want wb_empty"); end
    do_read(32'h54, d, ok);
    n_tests++;
    if (!ok || d !== 32'hE000_0003) begin
      n_fail++; $display("FAIL full_stall_last: got ok=%0d %h want e0000003", ok, d);
    end
  endtask

  task automatic test_capture_race();
    bit ok;
    logic [31:0] d;
    do_write(32'h08, 32'h0BAD_0008);
    wait_empty(ok);
    rd_req = 1'b1; rd_addr = 32'h08;
    step();  // edge N
    rd_req = 1'b0;
    step(); step(); step();
    wr_req = 1'b1; wr_addr = 32'h08; wr_data = 32'hAAAA_0001;
    step();  // edge N+4: capture and write acceptance together
    wr_req = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0BAD_0008) begin
      n_fail++; $display("FAIL race_old: got v=%b %h want v=1 0bad0008", rd_valid, rd_data);
    end
    step();
    do_read(32'h08, d, ok);
    n_tests++;
    if (!ok || d !== 32'hAAAA_0001) begin
      n_fail++; $display("FAIL race_new: got ok=%0d %h want aaaa0001", ok, d);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    bit seen;
    logic [31:0] d;
    do_write(32'h30, 32'h3030_3030);
    wait_empty(ok);
    force dut.w_pop = 1'b0;
    rd_req = 1'b1; rd_addr = 32'h30;
    wr_req = 1'b1; wr_addr = 32'h30; wr_data = 32'h5555_5555;
    step();  // edge N
    rd_req = 1'b0; wr_req = 1'b0;
    step(); step();
    n_tests++;
    if (wb_empty !== 1'b0) begin
      n_fail++; $display("FAIL rst_pre: got wb_empty=%b want 0", wb_empty);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({rd_valid, rd_ready, wr_ready, wb_empty} !== 4'b0111) begin
      n_fail++;
      $display("FAIL rst_mid_flags: got v/rr/wr/e=%b want 0111",
               {rd_valid, rd_ready, wr_ready, wb_empty});
    end
    release dut.w_pop;
    seen = 1'b0;
    step(); seen |= rd_valid;
    step(); seen |= rd_valid;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      seen |= rd_valid;
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL rst_no_valid: got rd_valid pulse want none"); end
    do_read(32'h30, d, ok);
    n_tests++;
    if (!ok || d !== 32'h3030_3030) begin
      n_fail++; $display("FAIL rst_lost_write: got ok=%0d %h want 30303030", ok, d);
    end
    do_read(32'h14, d, ok);
    n_tests++;
    if (!ok || d !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rst_array_kept: got ok=%0d %h want deadbeef", ok, d);
    end
  endtask

  task automatic test_alias();
    bit ok;
    logic [31:0] d;
    do_write(32'h0000_1004, 32'h7777_0001);
    wait_empty(ok);
    do_read(32'h0000_0004, d, ok);
    n_tests++;
    if (!ok || d !== 32'h7777_0001) begin
      n_fail++; $display("FAIL alias_hi: got ok=%0d %h want 77770001", ok, d);
    end
    do_read(32'hFFFF_F007, d, ok);
    n_tests++;
    if (!ok || d !== 32'h7777_0001) begin
      n_fail++; $display("FAIL alias_lo: got ok=%0d %h want 77770001", ok, d);
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_forward();
    test_full_buffer();
    test_capture_race();
    test_reset_mid_read();
    test_alias();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
